mem_access_ctrl: RTL and testbench

- Initiator side of the data-memory port: converts one load/store request from the multicycle MIPS datapath into MemRead/MemWrite/Address/WriteData cycles toward the Memory block, then returns the result.
- Handles byte, halfword and word accesses.
- Sub-word stores are performed as a read-modify-write, because Memory only writes full words.
- Extracts and sign-/zero-extends load data, and flags misaligned accesses without touching memory.

---
 rtl/mem_access_ctrl_if.sv | 32 +++
 rtl/mem_access_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Bus bundle between the load/store requester, the access controller and
// the data Memory. The master side is the environment (datapath plus
// Memory); the slave side is the controller itself.
interface mem_access_ctrl_if;
   // request side
   logic        Req;
   logic        Op;
   logic [1:0]  Size;
   logic        Unsigned;
   logic [31:0] Addr;
   logic [31:0] StoreData;
   logic [31:0] LoadData;
   logic        Done;
   logic        AlignErr;
   logic        Busy;
   // memory side
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic [31:0] MemData;

   modport master (
      output Req, Op, Size, Unsigned, Addr, StoreData, MemData,
      input  LoadData, Done, AlignErr, Busy, MemRead, MemWrite, Address, WriteData
   );

   modport slave (
      input  Req, Op, Size, Unsigned, Addr, StoreData, MemData,
      output LoadData, Done, AlignErr, Busy, MemRead, MemWrite, Address, WriteData
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller for the multicycle MIPS datapath.
// Turns one load/store request into MemRead/MemWrite cycles, performs
// sub-word stores as read-modify-write, extends load data and rejects
// misaligned accesses without touching memory.
// READ_LAT must be 1..15.
module mem_access_ctrl #(
   parameter int unsigned READ_LAT = 1
) (
   input logic             clk,
   input logic             reset,
   mem_access_ctrl_if.slave bus
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_RD     = 3'd1;
   localparam logic [2:0] S_RMW_RD = 3'd2;
   localparam logic [2:0] S_WR     = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [3:0] LAT_LAST = 4'(READ_LAT - 1);

   // Only the request fields still needed after acceptance are kept:
   // the op is encoded in the state path, the upper address bits live in
   // address_q and a full store word goes straight into write_data_q.
   logic [2:0]  state_q,      state_d;
   logic [1:0]  size_q,       size_d;
   logic        unsigned_q,   unsigned_d;
   logic [1:0]  addr_lo_q,    addr_lo_d;
   logic [15:0] store_lo_q,   store_lo_d;
   logic [3:0]  lat_cnt_q,    lat_cnt_d;
   logic [31:0] load_data_q,  load_data_d;
   logic        align_err_q,  align_err_d;
   logic [31:0] address_q,    address_d;
   logic [31:0] write_data_q, write_data_d;

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
      return (size == 2'b11) ||
             (size == SZ_HALF && lo[0]) ||
             (size == SZ_WORD && lo != 2'b00);
   endfunction

   // Little-endian lane extraction followed by sign or zero extension.
   function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] lo, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lo, 3'b000} +: 8];
      h = word[{lo[1], 4'b0000} +: 16];
      case (size)
         SZ_BYTE: return uns ? {24'd0, b} : {{24{b[7]}}, b};
         SZ_HALF: return uns ? {16'd0, h} : {{16{h[15]}}, h};
         default: return word;
      endcase
   endfunction

   // Replaces the addressed byte/half lane of the read word with store data.
   function automatic logic [31:0] merge(input logic [31:0] word, input logic [1:0] size,
                                         input logic [1:0] lo, input logic [15:0] data);
      logic [31:0] res;
      res = word;
      if (size == SZ_BYTE) res[{lo, 3'b000} +: 8]     = data[7:0];
      else                 res[{lo[1], 4'b0000} +: 16] = data;
      return res;
   endfunction

   // Next-state, latched-request and datapath register updates.
   always_comb begin
      // NOTE: every variable gets its hold value first so no path through the case infers a latch.
      state_d      = state_q;
      size_d       = size_q;
      unsigned_d   = unsigned_q;
      addr_lo_d    = addr_lo_q;
      store_lo_d   = store_lo_q;
      lat_cnt_d    = lat_cnt_q;
      load_data_d  = load_data_q;
      align_err_d  = align_err_q;
      address_d    = address_q;
      write_data_d = write_data_q;
      case (state_q)
         S_IDLE: begin
            if (bus.Req) begin
               size_d     = bus.Size;
               unsigned_d = bus.Unsigned;
               addr_lo_d  = bus.Addr[1:0];
               store_lo_d = bus.StoreData[15:0];
               lat_cnt_d  = 4'd0;
               if (misaligned(bus.Size, bus.Addr[1:0])) begin
                  // Memory-side registers are left alone so no bus activity appears.
                  align_err_d = 1'b1;
                  state_d     = S_DONE;
               end else begin
                  align_err_d = 1'b0;
                  address_d   = {bus.Addr[31:2], 2'b00};
                  if (!bus.Op) begin
                     state_d = S_RD;
                  end else if (bus.Size == SZ_WORD) begin
                     write_data_d = bus.StoreData;
                     state_d      = S_WR;
                  end else begin
                     state_d = S_RMW_RD;
                  end
               end
            end
         end
         S_RD, S_RMW_RD: begin
            if (lat_cnt_q == LAT_LAST) begin
               lat_cnt_d = 4'd0;
               if (state_q == S_RD) begin
                  load_data_d = extract(bus.MemData, size_q, addr_lo_q, unsigned_q);
                  state_d     = S_DONE;
               end else begin
                  write_data_d = merge(bus.MemData, size_q, addr_lo_q, store_lo_q);
                  state_d      = S_WR;
               end
            end else begin
               lat_cnt_d = lat_cnt_q + 4'd1;
            end
         end
         S_WR:    state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         size_q       <= 2'b00;
         unsigned_q   <= 1'b0;
         addr_lo_q    <= 2'b00;
         store_lo_q   <= 16'd0;
         lat_cnt_q    <= 4'd0;
         load_data_q  <= 32'd0;
         align_err_q  <= 1'b0;
         address_q    <= 32'd0;
         write_data_q <= 32'd0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q      <= state_d;
         size_q       <= size_d;
         unsigned_q   <= unsigned_d;
         addr_lo_q    <= addr_lo_d;
         store_lo_q   <= store_lo_d;
         lat_cnt_q    <= lat_cnt_d;
         load_data_q  <= load_data_d;
         align_err_q  <= align_err_d;
         address_q    <= address_d;
         write_data_q <= write_data_d;
      end
   end

   // Strobes and status decode straight from the registered state, so reset
   // forces them low immediately and they can never overlap.
   assign bus.MemRead   = (state_q == S_RD) || (state_q == S_RMW_RD);
   assign bus.MemWrite  = (state_q == S_WR);
   assign bus.Done      = (state_q == S_DONE);
   assign bus.AlignErr  = (state_q == S_DONE) && align_err_q;
   assign bus.Busy      = (state_q != S_IDLE);
   assign bus.Address   = address_q;
   assign bus.WriteData = write_data_q;
   assign bus.LoadData  = load_data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: one instance with READ_LAT=1 and
// one with READ_LAT=3, each with its own word memory. Expected results are
// queued when a request is driven and compared when Done appears.
module tb_mem_access_ctrl;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_access_ctrl_if b1 ();
   mem_access_ctrl_if b3 ();

   mem_access_ctrl #(.READ_LAT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
   mem_access_ctrl #(.READ_LAT(3)) u_dut3 (.clk(clk), .reset(reset), .bus(b3.slave));

   // shared request drive; sel chooses which instance sees Req
   logic        sel;
   logic        req;
   logic        op;
   logic [1:0]  size;
   logic        uns;
   logic [31:0] addr;
   logic [31:0] sdata;

   assign b1.Req = req & ~sel;
   assign b1.Op = op;
   assign b1.Size = size;
   assign b1.Unsigned = uns;
   assign b1.Addr = addr;
   assign b1.StoreData = sdata;
   assign b3.Req = req & sel;
   assign b3.Op = op;
   assign b3.Size = size;
   assign b3.Unsigned = uns;
   assign b3.Addr = addr;
   assign b3.StoreData = sdata;

   // word memories
   logic [31:0] mem1 [0:63];
   logic [31:0] mem3 [0:63];
   assign b1.MemData = mem1[b1.Address[7:2]];
   assign b3.MemData = mem3[b3.Address[7:2]];
   always @(posedge clk) if (b1.MemWrite) mem1[b1.Address[7:2]] <= b1.WriteData;
   always @(posedge clk) if (b3.MemWrite) mem3[b3.Address[7:2]] <= b3.WriteData;

   // outputs of the selected instance
   logic        done_m, err_m, busy_m, rd_m, wr_m;
   logic [31:0] ld_m, address_m, wdata_m;
   assign done_m    = sel ? b3.Done      : b1.Done;
   assign err_m     = sel ? b3.AlignErr  : b1.AlignErr;
   assign busy_m    = sel ? b3.Busy      : b1.Busy;
   assign rd_m      = sel ? b3.MemRead   : b1.MemRead;
   assign wr_m      = sel ? b3.MemWrite  : b1.MemWrite;
   assign ld_m      = sel ? b3.LoadData  : b1.LoadData;
   assign address_m = sel ? b3.Address   : b1.Address;
   assign wdata_m   = sel ? b3.WriteData : b1.WriteData;

   // bus monitor: strobe cycle totals, last write, overlap violations
   int          rd_total = 0;
   int          wr_total = 0;
   int          done_total = 0;
   int          viol = 0;
   logic [31:0] wr_last_addr = 32'd0;
   logic [31:0] wr_last_data = 32'd0;
   always @(negedge clk) begin
      if (rd_m) rd_total <= rd_total + 1;
      if (wr_m) begin
         wr_total     <= wr_total + 1;
         wr_last_addr <= address_m;
         wr_last_data <= wdata_m;
      end
      if (done_m) done_total <= done_total + 1;
      if ((b1.MemRead && b1.MemWrite) || (b3.MemRead && b3.MemWrite)) viol <= viol + 1;
   end

   typedef struct {
      string       name;
      logic [31:0] ld;
      logic        err;
      int          lat;
      int          rd;
      int          wr;
      logic [31:0] wdata;
      logic [31:0] waddr;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   // Called just after the acceptance edge; lat counts edges up to the one raising Done.
   task automatic wait_done(output int lat, output bit ok);
      lat = 0;
      ok  = 1'b0;
      while (!ok && lat < 40) begin
         if (lat > 0) @(posedge clk);
         lat++;
         @(negedge clk);
         if (done_m === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic run_req(input string name, input logic o, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] e_ld, input logic e_err, input int e_lat,
                          input int e_rd, input int e_wr, input logic [31:0] e_wdata);
      exp_t e;
      exp_t g;
      int   rd0, wr0, lat;
      bit   ok;
      e.name = name; e.ld = e_ld; e.err = e_err; e.lat = e_lat;
      e.rd = e_rd; e.wr = e_wr; e.wdata = e_wdata; e.waddr = {a[31:2], 2'b00};
      sb.push_back(e);
      @(posedge clk); #1;
      rd0 = rd_total;
      wr0 = wr_total;
      req = 1'b1; op = o; size = sz; uns = u; addr = a; sdata = sd;
      @(posedge clk); #1;
      // later input changes must be ignored
      req = 1'b0; op = ~o; size = ~sz; uns = ~u; addr = $urandom; sdata = $urandom;
      wait_done(lat, ok);
      g = sb.pop_front();
      tests++;
      if (!ok) begin fails++; $display("FAIL %s done_timeout: got no Done want Done", g.name); end
      tests++;
      if (lat != g.lat) begin fails++; $display("FAIL %s latency: got %0d want %0d", g.name, lat, g.lat); end
      tests++;
      if (ld_m !== g.ld) begin fails++; $display("FAIL %s load_data: got %h want %h", g.name, ld_m, g.ld); end
      tests++;
      if (err_m !== g.err) begin fails++; $display("FAIL %s align_err: got %b want %b", g.name, err_m, g.err); end
      tests++;
      if (rd_total - rd0 != g.rd) begin fails++; $display("FAIL %s memread_cycles: got %0d want %0d", g.name, rd_total - rd0, g.rd); end
      tests++;
      if (wr_total - wr0 != g.wr) begin fails++; $display("FAIL %s memwrite_cycles: got %0d want %0d", g.name, wr_total - wr0, g.wr); end
      if (g.wr > 0) begin
         tests++;
         if (wr_last_data !== g.wdata) begin fails++; $display("FAIL %s write_data: got %h want %h", g.name, wr_last_data, g.wdata); end
         tests++;
         if (wr_last_addr !== g.waddr) begin fails++; $display("FAIL %s write_addr: got %h want %h", g.name, wr_last_addr, g.waddr); end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      sel = 1'b0; req = 1'b0; op = 1'b0; size = 2'b00; uns = 1'b0; addr = 32'd0; sdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({b1.LoadData, b3.LoadData} !== 64'd0) begin fails++; $display("FAIL reset load_data: got %h %h want 0", b1.LoadData, b3.LoadData); end
      tests++;
      if ({b1.Done, b3.Done} !== 2'b00) begin fails++; $display("FAIL reset done: got %b%b want 00", b1.Done, b3.Done); end
      tests++;
      if ({b1.AlignErr, b3.AlignErr} !== 2'b00) begin fails++; $display("FAIL reset align_err: got %b%b want 00", b1.AlignErr, b3.AlignErr); end
      tests++;
      if ({b1.Busy, b3.Busy} !== 2'b00) begin fails++; $display("FAIL reset busy: got %b%b want 00", b1.Busy, b3.Busy); end
      tests++;
      if ({b1.MemRead, b3.MemRead} !== 2'b00) begin fails++; $display("FAIL reset memread: got %b%b want 00", b1.MemRead, b3.MemRead); end
      tests++;
      if ({b1.MemWrite, b3.MemWrite} !== 2'b00) begin fails++; $display("FAIL reset memwrite: got %b%b want 00", b1.MemWrite, b3.MemWrite); end
      tests++;
      if ({b1.Address, b3.Address} !== 64'd0) begin fails++; $display("FAIL reset address: got %h %h want 0", b1.Address, b3.Address); end
      tests++;
      if ({b1.WriteData, b3.WriteData} !== 64'd0) begin fails++; $display("FAIL reset write_data: got %h %h want 0", b1.WriteData, b3.WriteData); end
      reset = 1'b0;
   endtask

   task automatic test_word();
      run_req("sw_28", 1'b1, 2'b10, 1'b0, 32'h28, 32'hAAAAAAAA, 32'h0, 1'b0, 2, 0, 1, 32'hAAAAAAAA);
      run_req("lw_28", 1'b0, 2'b10, 1'b0, 32'h28, 32'h0, 32'hAAAAAAAA, 1'b0, 2, 1, 0, 32'h0);
   endtask

   task automatic test_byte_rmw();
      run_req("sw_14", 1'b1, 2'b10, 1'b0, 32'h14, 32'h11223344, 32'hAAAAAAAA, 1'b0, 2, 0, 1, 32'h11223344);
      run_req("sb_16", 1'b1, 2'b00, 1'b0, 32'h16, 32'h123456EE, 32'hAAAAAAAA, 1'b0, 3, 1, 1, 32'h11EE3344);
      run_req("lw_14_rmw", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h11EE3344, 1'b0, 2, 1, 0, 32'h0);
   endtask

   task automatic test_extension();
      run_req("sw_14_ext", 1'b1, 2'b10, 1'b0, 32'h14, 32'h000080F0, 32'h11EE3344, 1'b0, 2, 0, 1, 32'h000080F0);
      run_req("lb_15",  1'b0, 2'b00, 1'b0, 32'h15, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1, 0, 32'h0);
      run_req("lbu_15", 1'b0, 2'b00, 1'b1, 32'h15, 32'h0, 32'h00000080, 1'b0, 2, 1, 0, 32'h0);
      run_req("lh_14",  1'b0, 2'b01, 1'b0, 32'h14, 32'h0, 32'hFFFF80F0, 1'b0, 2, 1, 0, 32'h0);
      run_req("lhu_14", 1'b0, 2'b01, 1'b1, 32'h14, 32'h0, 32'h000080F0, 1'b0, 2, 1, 0, 32'h0);
      run_req("sh_16",  1'b1, 2'b01, 1'b0, 32'h16, 32'h1234ABCD, 32'h000080F0, 1'b0, 3, 1, 1, 32'hABCD80F0);
      run_req("lb_17",  1'b0, 2'b00, 1'b0, 32'h17, 32'h0, 32'hFFFFFFAB, 1'b0, 2, 1, 0, 32'h0);
   endtask

   task automatic test_alignment();
      run_req("lh_15_mis", 1'b0, 2'b01, 1'b0, 32'h15, 32'h0, 32'hFFFFFFAB, 1'b1, 1, 0, 0, 32'h0);
      run_req("sw_16_mis", 1'b1, 2'b10, 1'b0, 32'h16, 32'h55555555, 32'hFFFFFFAB, 1'b1, 1, 0, 0, 32'h0);
      run_req("ld_sz11",   1'b0, 2'b11, 1'b0, 32'h14, 32'h0, 32'hFFFFFFAB, 1'b1, 1, 0, 0, 32'h0);
      run_req("st_sz11",   1'b1, 2'b11, 1'b0, 32'h18, 32'h66666666, 32'hFFFFFFAB, 1'b1, 1, 0, 0, 32'h0);
   endtask

   task automatic test_back_to_back();
      exp_t e;
      exp_t g;
      int   lat, gap, idle;
      bit   ok;
      e.name = "b2b_lw_28"; e.ld = 32'hAAAAAAAA; e.err = 1'b0; e.lat = 2; e.rd = 1; e.wr = 0; e.wdata = 32'h0; e.waddr = 32'h28;
      sb.push_back(e);
      e.name = "b2b_lw_14"; e.ld = 32'hABCD80F0; e.waddr = 32'h14;
      sb.push_back(e);
      @(posedge clk); #1;
      req = 1'b1; op = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h28;
      @(posedge clk); #1;
      addr = 32'h14;
      wait_done(lat, ok);
      g = sb.pop_front();
      tests++;
      if (!ok || lat != g.lat) begin fails++; $display("FAIL %s latency: got %0d want %0d", g.name, lat, g.lat); end
      tests++;
      if (ld_m !== g.ld) begin fails++; $display("FAIL %s load_data: got %h want %h", g.name, ld_m, g.ld); end
      gap = 0; idle = 0; ok = 1'b0;
      while (!ok && gap < 20) begin
         @(posedge clk);
         gap++;
         @(negedge clk);
         if (done_m === 1'b1) ok = 1'b1;
         else if (busy_m === 1'b0) idle++;
         else req = 1'b0;
      end
      g = sb.pop_front();
      tests++;
      if (!ok || gap != 3) begin fails++; $display("FAIL b2b_gap: got %0d want 3", gap); end
      tests++;
      if (idle != 1) begin fails++; $display("FAIL b2b_idle_cycles: got %0d want 1", idle); end
      tests++;
      if (ld_m !== g.ld) begin fails++; $display("FAIL %s load_data: got %h want %h", g.name, ld_m, g.ld); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      tests++;
      if (busy_m !== 1'b0) begin fails++; $display("FAIL b2b_no_third: got busy %b want 0", busy_m); end
   endtask

   task automatic test_reset_mid();
      int wr0, done0;
      run_req("sw_20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h55667788, 32'hABCD80F0, 1'b0, 2, 0, 1, 32'h55667788);
      @(posedge clk); #1;
      req = 1'b1; op = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h21; sdata = 32'h00000099;
      @(posedge clk); #1;
      req = 1'b0;
      wr0   = wr_total;
      done0 = done_total;
      tests++;
      if (b1.MemRead !== 1'b1) begin fails++; $display("FAIL rst_mid in_rmw_rd: got memread %b want 1", b1.MemRead); end
      #2 reset = 1'b1;
      #1;
      tests++;
      if ({b1.MemRead, b1.MemWrite, b1.Busy, b1.Done} !== 4'b0000) begin
         fails++; $display("FAIL rst_mid strobes: got %b%b%b%b want 0000", b1.MemRead, b1.MemWrite, b1.Busy, b1.Done);
      end
      tests++;
      if ({b1.Address, b1.LoadData} !== 64'd0) begin fails++; $display("FAIL rst_mid regs: got %h %h want 0", b1.Address, b1.LoadData); end
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (wr_total != wr0) begin fails++; $display("FAIL rst_mid no_write: got %0d want %0d", wr_total, wr0); end
      tests++;
      if (done_total != done0) begin fails++; $display("FAIL rst_mid no_done: got %0d want %0d", done_total, done0); end
      run_req("lw_20_after_rst", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h55667788, 1'b0, 2, 1, 0, 32'h0);
   endtask

   task automatic test_read_lat3();
      sel = 1'b1;
      run_req("l3_sw_30",  1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFEF00D, 32'h0, 1'b0, 2, 0, 1, 32'hCAFEF00D);
      run_req("l3_lw_30",  1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0, 4, 3, 0, 32'h0);
      run_req("l3_sh_32",  1'b1, 2'b01, 1'b0, 32'h32, 32'h0000BEEF, 32'hCAFEF00D, 1'b0, 5, 3, 1, 32'hBEEFF00D);
      run_req("l3_lhu_32", 1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 32'h0000BEEF, 1'b0, 4, 3, 0, 32'h0);
      run_req("l3_lb_31",  1'b0, 2'b00, 1'b0, 32'h31, 32'h0, 32'hFFFFFFF0, 1'b0, 4, 3, 0, 32'h0);
      sel = 1'b0;
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte_rmw();
      test_extension();
      test_alignment();
      test_back_to_back();
      test_reset_mid();
      test_read_lat3();
      @(posedge clk); #1;
      tests++;
      if (viol != 0) begin fails++; $display("FAIL strobe_overlap: got %0d want 0", viol); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
